// File: rtl/vc_fifo_pop_arbiter.sv
// Read-side controller for the VC0/VC1 FIFO pair: weighted VC0-priority pop
// arbitration, then routes each returned word to destination D0/D1 by its MSB.
module vc_fifo_pop_arbiter #(
  parameter int unsigned data_width = 6,
  parameter int unsigned WEIGHT     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic [data_width-1:0] data_out_VC0,
  input  logic [data_width-1:0] data_out_VC1,
  input  logic                  almost_full_D0,
  input  logic                  almost_full_D1,
  output logic                  rd_enable_VC0,
  output logic                  rd_enable_VC1,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [data_width-1:0] data_to_D,
  output logic [1:0]            state,
  output logic                  idle
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] WeightC = CntW'(WEIGHT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_VC0 = 2'd1,
    GNT_VC1 = 2'd2,
    PAUSE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CntW-1:0]       burst_q, burst_d;
  logic                  v1_q, v1_d;
  logic                  src1_q, src1_d;
  logic                  push_d0_q, push_d0_d;
  logic                  push_d1_q, push_d1_d;
  logic [data_width-1:0] data_q, data_d;
  logic [data_width-1:0] word_c;
  logic                  pause_c;
  logic                  rd0_c, rd1_c;

  // Grant: VC0 wins until it has taken WEIGHT pops while VC1 waited.
  always_comb begin
    pause_c = almost_full_D0 | almost_full_D1;
    rd0_c   = 1'b0;
    rd1_c   = 1'b0;
    if (!reset && !pause_c) begin
      rd0_c = !empty_fifo_VC0 & (empty_fifo_VC1 | (burst_q < WeightC));
      rd1_c = !empty_fifo_VC1 & (empty_fifo_VC0 | (burst_q == WeightC));
    end
  end

  // Next-state for burst counter, FSM, stage-1 tag and stage-2 routing.
  always_comb begin
    burst_d   = burst_q;
    state_d   = IDLE;
    v1_d      = rd0_c | rd1_c;
    src1_d    = rd1_c;
    word_c    = src1_q ? data_out_VC1 : data_out_VC0;
    push_d0_d = 1'b0;
    push_d1_d = 1'b0;
    data_d    = data_q;

    if (rd1_c) begin
      burst_d = '0;
    end else if (rd0_c && !empty_fifo_VC1 && (burst_q < WeightC)) begin
      burst_d = burst_q + CntW'(1);
    end

    if (pause_c && (!empty_fifo_VC0 || !empty_fifo_VC1)) begin
      state_d = PAUSE;
    end else if (rd0_c) begin
      state_d = GNT_VC0;
    end else if (rd1_c) begin
      state_d = GNT_VC1;
    end

    if (v1_q) begin
      data_d    = word_c;
      push_d1_d = word_c[data_width-1];
      push_d0_d = !word_c[data_width-1];
    end

    // Reset dominates: in-flight words are dropped.
    if (reset) begin
      burst_d   = '0;
      state_d   = IDLE;
      v1_d      = 1'b0;
      src1_d    = 1'b0;
      push_d0_d = 1'b0;
      push_d1_d = 1'b0;
      data_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    burst_q   <= burst_d;
    state_q   <= state_d;
    v1_q      <= v1_d;
    src1_q    <= src1_d;
    push_d0_q <= push_d0_d;
    push_d1_q <= push_d1_d;
    data_q    <= data_d;
  end

  assign rd_enable_VC0 = rd0_c;
  assign rd_enable_VC1 = rd1_c;
  assign push_D0       = push_d0_q;
  assign push_D1       = push_d1_q;
  assign data_to_D     = data_q;
  assign state         = state_q;
  assign idle          = empty_fifo_VC0 & empty_fifo_VC1 & !v1_q & !push_d0_q & !push_d1_q;

endmodule

// File: tb/tb_vc_fifo_pop_arbiter.sv
// Bench for vc_fifo_pop_arbiter: queue-based VC FIFO models plus a scoreboard
// of popped words that must reappear at the destination two cycles later.
module tb_vc_fifo_pop_arbiter;

  localparam int unsigned DW = 6;
  localparam int unsigned W  = 3;

  logic          clk;
  logic          reset;
  logic          empty_fifo_VC0, empty_fifo_VC1;
  logic [DW-1:0] data_out_VC0, data_out_VC1;
  logic          almost_full_D0, almost_full_D1;
  logic          rd_enable_VC0, rd_enable_VC1;
  logic          push_D0, push_D1;
  logic [DW-1:0] data_to_D;
  logic [1:0]    state;
  logic          idle;

  vc_fifo_pop_arbiter #(.data_width(DW), .WEIGHT(W)) dut (
    .clk(clk), .reset(reset),
    .empty_fifo_VC0(empty_fifo_VC0), .empty_fifo_VC1(empty_fifo_VC1),
    .data_out_VC0(data_out_VC0), .data_out_VC1(data_out_VC1),
    .almost_full_D0(almost_full_D0), .almost_full_D1(almost_full_D1),
    .rd_enable_VC0(rd_enable_VC0), .rd_enable_VC1(rd_enable_VC1),
    .push_D0(push_D0), .push_D1(push_D1), .data_to_D(data_to_D),
    .state(state), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] w;
    int            due;
  } flight_t;

  logic [DW-1:0] vc0_q[$];
  logic [DW-1:0] vc1_q[$];
  flight_t       flights[$];

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            streak = 0;      // VC0 pops since VC1 last popped, counted while VC1 waited
  int            m_state = 0;
  logic [DW-1:0] m_data = '0;
  bit            skip_reg = 1'b1; // registers are unknown before the first reset edge
  int            pushes = 0;

  // One clock cycle: drive inputs, check all outputs against the model, advance.
  task automatic cycle(input bit rst, input bit af0, input bit af1);
    bit e0, e1, pause, g0, g1, hit, r0, r1;
    logic [DW-1:0] w;
    @(negedge clk);
    reset          = rst;
    almost_full_D0 = af0;
    almost_full_D1 = af1;
    e0 = (vc0_q.size() == 0);
    e1 = (vc1_q.size() == 0);
    empty_fifo_VC0 = e0;
    empty_fifo_VC1 = e1;
    #1;
    pause = af0 | af1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && !pause) begin
      if (!e0 && !e1) begin
        g1 = (streak >= int'(W));
        g0 = !g1;
      end else begin
        g0 = !e0;
        g1 = !e1;
      end
    end
    checks++;
    if (rd_enable_VC0 !== g0) begin
      errors++;
      $display("FAIL rd_enable_VC0 cyc=%0d got=%b exp=%b", cyc, rd_enable_VC0, g0);
    end
    checks++;
    if (rd_enable_VC1 !== g1) begin
      errors++;
      $display("FAIL rd_enable_VC1 cyc=%0d got=%b exp=%b", cyc, rd_enable_VC1, g1);
    end
    hit = (flights.size() > 0) && (flights[0].due == cyc);
    w   = hit ? flights[0].w : m_data;
    if (!skip_reg) begin
      checks++;
      if (push_D0 !== (hit && !w[DW-1])) begin
        errors++;
        $display("FAIL push_D0 cyc=%0d got=%b exp=%b", cyc, push_D0, hit && !w[DW-1]);
      end
      checks++;
      if (push_D1 !== (hit && w[DW-1])) begin
        errors++;
        $display("FAIL push_D1 cyc=%0d got=%b exp=%b", cyc, push_D1, hit && w[DW-1]);
      end
      checks++;
      if (data_to_D !== w) begin
        errors++;
        $display("FAIL data_to_D cyc=%0d got=%h exp=%h", cyc, data_to_D, w);
      end
      checks++;
      if (state !== 2'(m_state)) begin
        errors++;
        $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, state, m_state);
      end
      checks++;
      if (idle !== (e0 && e1 && flights.size() == 0)) begin
        errors++;
        $display("FAIL idle cyc=%0d got=%b exp=%b", cyc, idle, e0 && e1 && flights.size() == 0);
      end
    end
    if (hit) begin
      m_data = w;
      void'(flights.pop_front());
      pushes++;
    end
    if (g0) begin
      flights.push_back('{w: vc0_q[0], due: cyc + 2});
      if (!e1) streak++;
    end
    if (g1) begin
      flights.push_back('{w: vc1_q[0], due: cyc + 2});
      streak = 0;
    end
    if (rst) m_state = 0;
    else if (pause && (!e0 || !e1)) m_state = 3;
    else if (g0) m_state = 1;
    else if (g1) m_state = 2;
    else m_state = 0;
    if (rst) begin
      streak = 0;
      m_data = '0;
      flights.delete();
    end
    r0 = rd_enable_VC0;
    r1 = rd_enable_VC1;
    @(posedge clk);
    #1;
    if (r0 && vc0_q.size() > 0) data_out_VC0 = vc0_q.pop_front();
    if (r1 && vc1_q.size() > 0) data_out_VC1 = vc1_q.pop_front();
    empty_fifo_VC0 = (vc0_q.size() == 0);
    empty_fifo_VC1 = (vc1_q.size() == 0);
    skip_reg = 1'b0;
    cyc++;
  endtask

  task automatic clean_start();
    vc0_q.delete();
    vc1_q.delete();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    vc0_q = '{6'h01, 6'h22, 6'h03};
    vc1_q = '{6'h24, 6'h05};
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=0", idle);
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_word();
    clean_start();
    vc0_q.push_back(6'b000101);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (data_to_D !== 6'b000101 || idle !== 1'b1) begin
      errors++;
      $display("FAIL single_word data=%h idle=%b exp data=05 idle=1", data_to_D, idle);
    end
  endtask

  task automatic test_routing();
    int p0;
    clean_start();
    vc1_q = '{6'b100011, 6'b000111, 6'b111111};
    p0 = pushes;
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (pushes - p0 != 3) begin
      errors++;
      $display("FAIL routing_count got=%0d exp=3", pushes - p0);
    end
  endtask

  task automatic test_weighted();
    clean_start();
    for (int i = 0; i < 8; i++) begin
      vc0_q.push_back(DW'($urandom));
      vc1_q.push_back(DW'($urandom));
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    clean_start();
    for (int i = 0; i < 16; i++) vc0_q.push_back(DW'($urandom));
    for (int i = 0; i < 24; i++) cycle(1'b0, (i >= 10 && i <= 14), 1'b0);
  endtask

  task automatic test_reset_mid();
    clean_start();
    for (int i = 0; i < 6; i++) begin
      vc0_q.push_back(DW'($urandom));
      vc1_q.push_back(DW'($urandom));
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    clean_start();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) vc0_q.push_back(DW'($urandom));
      if ($urandom_range(0, 3) == 0) vc1_q.push_back(DW'($urandom));
      cycle($urandom_range(0, 60) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 8) == 0);
    end
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (idle !== 1'b1 || flights.size() != 0) begin
      errors++;
      $display("FAIL random_drain idle=%b pending=%0d exp idle=1 pending=0", idle, flights.size());
    end
  endtask

  initial begin
    reset          = 1'b1;
    empty_fifo_VC0 = 1'b1;
    empty_fifo_VC1 = 1'b1;
    data_out_VC0   = '0;
    data_out_VC1   = '0;
    almost_full_D0 = 1'b0;
    almost_full_D1 = 1'b0;
    test_reset();
    test_single_word();
    test_routing();
    test_weighted();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
